// File: rtl/weighted_burst_arbiter.sv
// Round-robin burst arbiter that moves words from a set of FWFT source FIFOs
// into a single sink FIFO, granting each owner up to MAX_BURST words.
module weighted_burst_arbiter #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned BURST_W = 8
) (
  input  logic                      BUS_CLK,
  input  logic                      BUS_RST,
  input  logic [WIDTH-1:0]          ENABLE_MASK,
  input  logic [BURST_W-1:0]        MAX_BURST,
  input  logic [WIDTH-1:0]          WRITE_REQ,
  input  logic [WIDTH-1:0]          HOLD_REQ,
  input  logic [WIDTH*DWIDTH-1:0]   DATA_IN,
  input  logic                      SINK_READY,
  output logic [WIDTH-1:0]          READ_GRANT,
  output logic                      WRITE_OUT,
  output logic [DWIDTH-1:0]         DATA_OUT,
  output logic [WIDTH-1:0]          OWNER
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNT_W = BURST_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   last_owner;
  logic [IDX_W-1:0]   pick;
  logic               found;
  logic [WIDTH-1:0]   cand;
  logic [BURST_W-1:0] burst_cnt;
  logic               owner_req;
  logic               owner_en;
  logic               owner_hold;
  logic               pop;
  logic               limit_hit;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    cand  = WRITE_REQ & ENABLE_MASK;
    found = 1'b0;
    pick  = last_owner;
    for (int unsigned i = 1; i <= WIDTH; i++) begin
      if (!found && cand[(32'(last_owner) + i) % WIDTH]) begin
        found = 1'b1;
        pick  = IDX_W'((32'(last_owner) + i) % WIDTH);
      end
    end
  end

  // last_owner doubles as the owner index while in BURST.
  always_comb begin
    owner_req  = WRITE_REQ[last_owner];
    owner_en   = ENABLE_MASK[last_owner];
    owner_hold = HOLD_REQ[last_owner];
    pop        = (state == BURST) && owner_req && SINK_READY && owner_en && !BUS_RST;
    READ_GRANT = pop ? (WIDTH'(1) << last_owner) : '0;
    limit_hit  = (MAX_BURST != '0) &&
                 ((CNT_W'(burst_cnt) + CNT_W'(pop)) >= CNT_W'(MAX_BURST));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (found) state_nxt = BURST;
      end
      BURST: begin
        if (!owner_en || (!owner_hold && (limit_hit || !owner_req))) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      OWNER      <= '0;
      last_owner <= IDX_W'(WIDTH - 1);
      burst_cnt  <= '0;
      WRITE_OUT  <= 1'b0;
      DATA_OUT   <= '0;
    end else begin
      WRITE_OUT <= pop;
      if (pop) begin
        DATA_OUT <= DATA_IN[32'(last_owner)*DWIDTH +: DWIDTH];
        if (burst_cnt != '1) burst_cnt <= burst_cnt + BURST_W'(1);
      end
      if (state == IDLE && found) begin
        OWNER      <= WIDTH'(1) << pick;
        last_owner <= pick;
        burst_cnt  <= '0;
      end else if (state == BURST && state_nxt == IDLE) begin
        OWNER <= '0;
      end
    end
  end

endmodule

// File: tb/tb_weighted_burst_arbiter.sv
// Scoreboard bench for weighted_burst_arbiter: modelled source FIFOs feed the
// DUT, popped words are queued and matched against the sink write stream.
module tb_weighted_burst_arbiter;

  localparam int unsigned WIDTH   = 6;
  localparam int unsigned DWIDTH  = 32;
  localparam int unsigned BURST_W = 8;
  localparam int unsigned DEPTH   = 16;

  logic                    clk;
  logic                    rst;
  logic [WIDTH-1:0]        mask;
  logic [BURST_W-1:0]      max_burst;
  logic [WIDTH-1:0]        req;
  logic [WIDTH-1:0]        hold;
  logic [WIDTH*DWIDTH-1:0] data_in;
  logic                    sink;
  logic [WIDTH-1:0]        grant;
  logic                    write_out;
  logic [DWIDTH-1:0]       data_out;
  logic [WIDTH-1:0]        owner;

  logic [DWIDTH-1:0] mem [WIDTH][DEPTH];
  int unsigned       rd [WIDTH];
  int unsigned       wr [WIDTH];
  int unsigned       pops [WIDTH];
  logic [DWIDTH-1:0] sb [$];
  int                seq;
  int                cyc;
  int                n_checks;
  int                n_errors;
  logic [DWIDTH-1:0] exp_w;

  weighted_burst_arbiter #(
    .WIDTH  (WIDTH),
    .DWIDTH (DWIDTH),
    .BURST_W(BURST_W)
  ) dut (
    .BUS_CLK    (clk),
    .BUS_RST    (rst),
    .ENABLE_MASK(mask),
    .MAX_BURST  (max_burst),
    .WRITE_REQ  (req),
    .HOLD_REQ   (hold),
    .DATA_IN    (data_in),
    .SINK_READY (sink),
    .READ_GRANT (grant),
    .WRITE_OUT  (write_out),
    .DATA_OUT   (data_out),
    .OWNER      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int src, input int n);
    for (int j = 0; j < n; j++) begin
      mem[src][wr[src] % DEPTH] = {8'(src), 24'(seq)};
      seq++;
      wr[src]++;
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < WIDTH; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
  endtask

  // One clock: drive FWFT sources, check the pop strobe, then the registered outputs.
  task automatic cycle(input logic [WIDTH-1:0] exp_grant, input logic [WIDTH-1:0] exp_owner);
    logic [WIDTH-1:0] g;
    for (int i = 0; i < WIDTH; i++) begin
      req[i] = (wr[i] != rd[i]);
      data_in[i*DWIDTH +: DWIDTH] = req[i] ? mem[i][rd[i] % DEPTH] : '0;
    end
    #1;
    g = grant;
    check("grant", 64'(g), 64'(exp_grant));
    for (int i = 0; i < WIDTH; i++) begin
      if (g[i]) begin
        check("pop_nonempty", 64'(wr[i] != rd[i]), 64'(1));
        if (wr[i] != rd[i]) begin
          sb.push_back(mem[i][rd[i] % DEPTH]);
          rd[i]++;
          pops[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("write_out", 64'(write_out), 64'((g != '0) && !rst));
    if (write_out) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) check("data_out", 64'(data_out), 64'(sb.pop_front()));
    end
    check("owner", 64'(owner), 64'(exp_owner));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_sources();
    hold = '0;
    mask = '1;
    sink = 1'b1;
    max_burst = '0;
    cycle('0, '0);
    cycle('0, '0);
    rst = 1'b0;
    check("rst_data", 64'(data_out), 64'(0));
    for (int i = 0; i < WIDTH; i++) pops[i] = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    seq = 1;
    cyc = 0;
    req = '0;
    data_in = '0;
    for (int i = 0; i < WIDTH; i++) pops[i] = 0;
    do_reset();

    // Fairness between sources 0 and 2, two words per grant.
    max_burst = 8'd2;
    push(0, 8);
    push(2, 8);
    cycle(6'h00, 6'h01); cycle(6'h01, 6'h01); cycle(6'h01, 6'h00);
    cycle(6'h00, 6'h04); cycle(6'h04, 6'h04); cycle(6'h04, 6'h00);
    cycle(6'h00, 6'h01); cycle(6'h01, 6'h01); cycle(6'h01, 6'h00);
    cycle(6'h00, 6'h04); cycle(6'h04, 6'h04); cycle(6'h04, 6'h00);
    check("fair_pops0", 64'(pops[0]), 64'(4));
    check("fair_pops2", 64'(pops[2]), 64'(4));
    check("fair_sb", 64'(sb.size()), 64'(0));

    // Single-word source exits on empty.
    do_reset();
    exp_w = {8'd3, 24'(seq)};
    push(3, 1);
    cycle(6'h00, 6'h08);
    cycle(6'h08, 6'h08);
    check("empty_data", 64'(data_out), 64'(exp_w));
    cycle(6'h00, 6'h00);
    cycle(6'h00, 6'h00);

    // Hold keeps ownership across empty and past the limit.
    do_reset();
    max_burst = 8'd1;
    hold = 6'h01;
    push(0, 1);
    push(1, 3);
    cycle(6'h00, 6'h01); cycle(6'h01, 6'h01); cycle(6'h00, 6'h01); cycle(6'h00, 6'h01);
    push(0, 4);
    cycle(6'h01, 6'h01); cycle(6'h01, 6'h01); cycle(6'h01, 6'h01); cycle(6'h01, 6'h01);
    cycle(6'h00, 6'h01);
    check("hold_pops0", 64'(pops[0]), 64'(5));
    check("hold_pops1", 64'(pops[1]), 64'(0));
    hold = 6'h00;
    cycle(6'h00, 6'h00); cycle(6'h00, 6'h02); cycle(6'h02, 6'h00);
    check("hold_pops1_after", 64'(pops[1]), 64'(1));

    // Backpressure during a burst from source 4.
    do_reset();
    max_burst = 8'd2;
    push(4, 5);
    sink = 1'b1; cycle(6'h00, 6'h10);
    sink = 1'b1; cycle(6'h10, 6'h10);
    sink = 1'b0; cycle(6'h00, 6'h10);
    sink = 1'b0; cycle(6'h00, 6'h10);
    sink = 1'b1; cycle(6'h10, 6'h00);
    check("bp_pops4", 64'(pops[4]), 64'(2));
    cycle(6'h00, 6'h10);
    check("bp_sb", 64'(sb.size()), 64'(0));

    // Mask drop mid-burst, then reset mid-burst.
    do_reset();
    hold = 6'h02;
    push(1, 8);
    cycle(6'h00, 6'h02); cycle(6'h02, 6'h02); cycle(6'h02, 6'h02);
    mask = 6'h3d;
    cycle(6'h00, 6'h00);
    mask = 6'h3f;
    cycle(6'h00, 6'h02); cycle(6'h02, 6'h02);
    push(2, 2);
    push(4, 2);
    cycle(6'h02, 6'h02);
    rst = 1'b1;
    cycle(6'h00, 6'h00);
    check("midrst_data", 64'(data_out), 64'(0));
    rst = 1'b0;
    cycle(6'h00, 6'h02);
    cycle(6'h02, 6'h02);
    check("final_sb", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
